// File: rtl/clint_ahb_bridge_if.sv
// AHB-Lite slave-side bus bundle for the CLINT bridge.
// The master modport drives the address/data phase; the slave modport answers.
interface clint_ahb_bridge_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/clint_ahb_bridge.sv
// AHB-Lite to CLINT register bridge.
// Decodes an accepted address phase into a one-hot CLINT register select,
// issues a zero-wait write strobe or a one-wait-state read, and answers
// illegal requests.
// Optional feature macro: CLINT_BRIDGE_ERR_EN -- when defined, illegal
// requests get a two-cycle ERROR response; otherwise illegal writes are
// dropped with OKAY and illegal reads return zero with OKAY.
module clint_ahb_bridge #(
  parameter logic [15:0] MSIP_OFF     = 16'h0000,
  parameter logic [15:0] MTIMECMP_OFF = 16'h4000,
  parameter logic [15:0] MTIME_OFF    = 16'hBFF8
) (
  input  logic                     CLK,
  input  logic                     nRST,
  clint_ahb_bridge_if.slave        ahb,
  input  logic [31:0]              clint_rdata,
  output logic                     mtime_sel,
  output logic                     mtimeh_sel,
  output logic                     mtimecmp_sel,
  output logic                     mtimecmph_sel,
  output logic                     msip_sel,
  output logic                     clint_wen,
  output logic                     clint_ren,
  output logic [31:0]              clint_wdata,
  output logic [31:0]              clint_addr
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_RD2  = 3'd3;
`ifdef CLINT_BRIDGE_ERR_EN
  localparam logic [2:0] S_ERR1 = 3'd4;
  localparam logic [2:0] S_ERR2 = 3'd5;
`endif

  // Select vector bit order: {msip, mtimecmph, mtimecmp, mtimeh, mtime}
  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [4:0]  r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_rdata;

  logic [15:0] w_off;
  logic [4:0]  w_dec;
  logic        w_legal;
  logic        w_accept;
  logic        w_slot;
  logic        w_take;
  logic        w_active;
  logic        w_readyout;
  logic        w_resp;

  // HTRANS[0] only distinguishes SEQ from NONSEQ, which the bridge treats alike.
  logic        w_unused_ok;
  assign w_unused_ok = ahb.HTRANS[0];

  assign w_off    = ahb.HADDR[15:0];
  assign w_accept = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign w_slot   = w_readyout;
  assign w_take   = w_accept & w_slot;

  // Offset decode into a one-hot select plus the legality check.
  always_comb begin
    w_dec = 5'b00000;
    if (w_off == MSIP_OFF)                     w_dec[4] = 1'b1;
    else if (w_off == MTIMECMP_OFF + 16'd4)    w_dec[3] = 1'b1;
    else if (w_off == MTIMECMP_OFF)            w_dec[2] = 1'b1;
    else if (w_off == MTIME_OFF + 16'd4)       w_dec[1] = 1'b1;
    else if (w_off == MTIME_OFF)               w_dec[0] = 1'b1;
    w_legal = (|w_dec) && (ahb.HADDR[1:0] == 2'b00) && (ahb.HSIZE == 3'b010);
  end

  // Next-state logic; accepts are only taken in cycles where HREADYOUT is high.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_RD1:  w_state_nxt = S_RD2;
`ifdef CLINT_BRIDGE_ERR_EN
      S_ERR1: w_state_nxt = S_ERR2;
`endif
      default: begin
        if (w_take) begin
`ifdef CLINT_BRIDGE_ERR_EN
          if (!w_legal)        w_state_nxt = S_ERR1;
          else if (ahb.HWRITE) w_state_nxt = S_WR;
          else                 w_state_nxt = S_RD1;
`else
          // Illegal requests still walk the normal path, just with no select.
          if (ahb.HWRITE) w_state_nxt = S_WR;
          else            w_state_nxt = S_RD1;
`endif
        end
      end
    endcase
  end

  // State register; reset drops any transfer in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Latch address and decoded select at each accepted address phase.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sel  <= 5'b00000;
      r_addr <= 32'h0;
    end else if (w_take) begin
      r_sel  <= w_legal ? w_dec : 5'b00000;
      r_addr <= ahb.HADDR;
    end
  end

  // Capture CLINT read data in RD1; an unselected (illegal) read yields zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                  r_rdata <= 32'h0;
    else if (r_state == S_RD1)  r_rdata <= (|r_sel) ? clint_rdata : 32'h0;
  end

  assign w_active   = (r_state == S_WR) || (r_state == S_RD1);
`ifdef CLINT_BRIDGE_ERR_EN
  assign w_readyout = (r_state != S_RD1) && (r_state != S_ERR1);
  assign w_resp     = (r_state == S_ERR1) || (r_state == S_ERR2);
`else
  assign w_readyout = (r_state != S_RD1);
  assign w_resp     = 1'b0;
`endif

  assign msip_sel      = w_active & r_sel[4];
  assign mtimecmph_sel = w_active & r_sel[3];
  assign mtimecmp_sel  = w_active & r_sel[2];
  assign mtimeh_sel    = w_active & r_sel[1];
  assign mtime_sel     = w_active & r_sel[0];
  assign clint_wen     = (r_state == S_WR)  & (|r_sel);
  assign clint_ren     = (r_state == S_RD1) & (|r_sel);
  assign clint_wdata   = ahb.HWDATA;
  assign clint_addr    = r_addr;

  assign ahb.HRDATA    = r_rdata;
  assign ahb.HREADYOUT = w_readyout;
  assign ahb.HRESP     = w_resp;

endmodule

// File: tb/tb_clint_ahb_bridge.sv
// Directed testbench for clint_ahb_bridge with hand-computed expectations.
module tb_clint_ahb_bridge;
  logic        CLK;
  logic        nRST;
  logic [31:0] clint_rdata;
  logic        mtime_sel, mtimeh_sel, mtimecmp_sel, mtimecmph_sel, msip_sel;
  logic        clint_wen, clint_ren;
  logic [31:0] clint_wdata, clint_addr;

  int n_checks = 0;
  int n_pass   = 0;

  clint_ahb_bridge_if bus ();

  // Single-slave system: bus-wide HREADY follows this slave.
  assign bus.HREADY = bus.HREADYOUT;

  clint_ahb_bridge dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ahb           (bus.slave),
    .clint_rdata   (clint_rdata),
    .mtime_sel     (mtime_sel),
    .mtimeh_sel    (mtimeh_sel),
    .mtimecmp_sel  (mtimecmp_sel),
    .mtimecmph_sel (mtimecmph_sel),
    .msip_sel      (msip_sel),
    .clint_wen     (clint_wen),
    .clint_ren     (clint_ren),
    .clint_wdata   (clint_wdata),
    .clint_addr    (clint_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Packed view of the selects: {msip, mtimecmph, mtimecmp, mtimeh, mtime}
  function automatic logic [31:0] sels();
    return {27'd0, msip_sel, mtimecmph_sel, mtimecmp_sel, mtimeh_sel, mtime_sel};
  endfunction

  function automatic logic [31:0] strobes();
    return {30'd0, clint_wen, clint_ren};
  endfunction

  // Drive an address phase at the falling edge; it is accepted at the next rising edge.
  task automatic addr_phase(input logic sel, input logic [1:0] trans, input logic wr,
                            input logic [31:0] addr, input logic [2:0] size);
    @(negedge CLK);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
  endtask

  task automatic idle_phase();
    @(negedge CLK);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  initial begin
    nRST        = 1'b0;
    clint_rdata = 32'h0;
    bus.HSEL    = 1'b0;
    bus.HADDR   = 32'h0;
    bus.HTRANS  = 2'b00;
    bus.HWRITE  = 1'b0;
    bus.HSIZE   = 3'b010;
    bus.HWDATA  = 32'h0;

    // Reset state
    #1;
    check("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
    check("rst_hresp",     {31'd0, bus.HRESP},     32'd0);
    check("rst_hrdata",    bus.HRDATA,             32'h0);
    check("rst_sels",      sels(),                 32'h0);
    check("rst_strobes",   strobes(),              32'h0);
    check("rst_addr",      clint_addr,             32'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // Write msip
    addr_phase(1'b1, 2'b10, 1'b1, 32'h0000_0000, 3'b010);
    idle_phase();
    bus.HWDATA = 32'h0000_0001;
    #1;
    check("wr_msip_sel",   sels(),                 32'h10);
    check("wr_msip_wen",   strobes(),              32'h2);
    check("wr_msip_wdata", clint_wdata,            32'h1);
    check("wr_msip_rdy",   {31'd0, bus.HREADYOUT}, 32'd1);
    check("wr_msip_resp",  {31'd0, bus.HRESP},     32'd0);

    // Read mtimecmph
    addr_phase(1'b1, 2'b10, 1'b0, 32'h0000_4004, 3'b010);
    idle_phase();
    clint_rdata = 32'hDEAD_BEEF;
    #1;
    check("rd1_rdy",   {31'd0, bus.HREADYOUT}, 32'd0);
    check("rd1_sel",   sels(),                 32'h08);
    check("rd1_ren",   strobes(),              32'h1);
    check("rd1_addr",  clint_addr,             32'h0000_4004);
    @(negedge CLK);
    clint_rdata = 32'h0;
    #1;
    check("rd2_data",  bus.HRDATA,             32'hDEAD_BEEF);
    check("rd2_rdy",   {31'd0, bus.HREADYOUT}, 32'd1);
    check("rd2_sels",  sels(),                 32'h0);

    // Back-to-back: write mtime then read mtimeh with no idle gap
    addr_phase(1'b1, 2'b10, 1'b1, 32'h0000_BFF8, 3'b010);
    addr_phase(1'b1, 2'b10, 1'b0, 32'h0000_BFFC, 3'b010);
    bus.HWDATA = 32'h0000_1234;
    #1;
    check("b2b_wr_sel",   sels(),                 32'h01);
    check("b2b_wr_str",   strobes(),              32'h2);
    check("b2b_wr_data",  clint_wdata,            32'h0000_1234);
    check("b2b_wr_rdy",   {31'd0, bus.HREADYOUT}, 32'd1);
    idle_phase();
    clint_rdata = 32'hCAFE_0001;
    #1;
    check("b2b_rd1_sel",  sels(),                 32'h02);
    check("b2b_rd1_str",  strobes(),              32'h1);
    check("b2b_rd1_rdy",  {31'd0, bus.HREADYOUT}, 32'd0);
    @(negedge CLK);
    clint_rdata = 32'h0;
    #1;
    check("b2b_rd2_data", bus.HRDATA,             32'hCAFE_0001);
    check("b2b_rd2_rdy",  {31'd0, bus.HREADYOUT}, 32'd1);
    check("b2b_rd2_sels", sels(),                 32'h0);

    // Reset asserted during RD1
    addr_phase(1'b1, 2'b10, 1'b0, 32'h0000_0000, 3'b010);
    idle_phase();
    clint_rdata = 32'h1111_2222;
    #1;
    check("rstrd_pre_ren", strobes(),              32'h1);
    nRST = 1'b0;
    #1;
    check("rstrd_rdy",     {31'd0, bus.HREADYOUT}, 32'd1);
    check("rstrd_str",     strobes(),              32'h0);
    check("rstrd_sels",    sels(),                 32'h0);
    check("rstrd_hrdata",  bus.HRDATA,             32'h0);
    check("rstrd_addr",    clint_addr,             32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    clint_rdata = 32'h0;
    addr_phase(1'b1, 2'b10, 1'b0, 32'h0000_4000, 3'b010);
    idle_phase();
    clint_rdata = 32'h0BAD_F00D;
    #1;
    check("post_rst_sel",  sels(),                 32'h04);
    check("post_rst_rdy",  {31'd0, bus.HREADYOUT}, 32'd0);
    @(negedge CLK);
    clint_rdata = 32'h0;
    #1;
    check("post_rst_data", bus.HRDATA,             32'h0BAD_F00D);

    // Idle / deselected / BUSY slots
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      bus.HSEL   = (i % 2) == 0;
      bus.HTRANS = (i == 2) ? 2'b01 : ((i % 2) == 0 ? 2'b00 : 2'b10);
      bus.HWRITE = 1'b1;
      bus.HADDR  = 32'h0000_0000;
      #1;
      check($sformatf("idle_sels%0d", i), sels() | strobes(), 32'h0);
      check($sformatf("idle_rdy%0d", i),  {30'd0, bus.HREADYOUT, bus.HRESP}, 32'h2);
    end

    // Illegal read offset
    addr_phase(1'b1, 2'b10, 1'b0, 32'h0000_0010, 3'b010);
    idle_phase();
    clint_rdata = 32'h5555_5555;
    #1;
    check("ill_rd_c1_str",  sels() | strobes(),     32'h0);
    check("ill_rd_c1_rdy",  {31'd0, bus.HREADYOUT}, 32'd0);
`ifdef CLINT_BRIDGE_ERR_EN
    check("ill_rd_c1_resp", {31'd0, bus.HRESP},     32'd1);
`else
    check("ill_rd_c1_resp", {31'd0, bus.HRESP},     32'd0);
`endif
    @(negedge CLK);
    clint_rdata = 32'h0;
    #1;
    check("ill_rd_c2_rdy",  {31'd0, bus.HREADYOUT}, 32'd1);
`ifdef CLINT_BRIDGE_ERR_EN
    check("ill_rd_c2_resp", {31'd0, bus.HRESP},     32'd1);
`else
    check("ill_rd_c2_resp", {31'd0, bus.HRESP},     32'd0);
    check("ill_rd_c2_data", bus.HRDATA,             32'h0);
`endif

    // Illegal size on a write to a valid register
    addr_phase(1'b1, 2'b10, 1'b1, 32'h0000_0000, 3'b000);
    idle_phase();
    bus.HSIZE  = 3'b010;
    bus.HWDATA = 32'h0000_00FF;
    #1;
    check("ill_sz_c1_str", sels() | strobes(), 32'h0);
`ifdef CLINT_BRIDGE_ERR_EN
    check("ill_sz_c1_rsp", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'h1);
    @(negedge CLK);
    #1;
    check("ill_sz_c2_rsp", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'h3);
    check("ill_sz_c2_str", sels() | strobes(), 32'h0);
`else
    check("ill_sz_c1_rsp", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'h2);
    @(negedge CLK);
    #1;
    check("ill_sz_c2_rsp", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'h2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
